// File: rtl/multicycle_ctrl_if.sv
// Instruction- and data-port handshake bundle for multicycle_ctrl.
// The master modport is the sequencer side; the slave modport is the memory side.
interface multicycle_ctrl_if;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;

    modport master (
        output imem_req,
        input  imem_ack,
        input  imem_rdata,
        output dmem_req,
        output dmem_we,
        input  dmem_ack
    );

    modport slave (
        input  imem_req,
        output imem_ack,
        output imem_rdata,
        input  dmem_req,
        input  dmem_we,
        output dmem_ack
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH, DECODE, EXEC, WAIT, then MEM, WB or BR.
// Optional PERF_CNT_EN adds free-running cycle and retired-instruction counters.
module multicycle_ctrl #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    multicycle_ctrl_if.master   bus,
    output logic [31:0]         ir,
    output logic [11:0]         alu_op,
    output logic [1:0]          opr2_sel,
    input  logic                alu_zero,
    output logic                rf_we,
    output logic                rf_wsel,
    output logic                pc_we,
    output logic                pc_sel,
    output logic                illegal
`ifdef PERF_CNT_EN
    ,
    output logic [XLEN-1:0]     cycle_cnt,
    output logic [XLEN-1:0]     instret_cnt
`endif
);

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, WAIT, MEM, WB, BR
    } state_t;

    state_t state, nxt;

    // The PC itself lives in the datapath; this value is only carried along.
    logic unused_cfg;
    assign unused_cfg = ^RESET_PC;

    logic [6:0] opc;
    logic [2:0] f3;
    assign opc = ir[6:0];
    assign f3  = ir[14:12];

    logic is_lui, is_auipc, is_jal, is_jalr, is_br;
    logic is_ld, is_st, is_opi, is_op, legal;
    assign is_lui   = (opc == 7'b0110111);
    assign is_auipc = (opc == 7'b0010111);
    assign is_jal   = (opc == 7'b1101111);
    assign is_jalr  = (opc == 7'b1100111);
    assign is_br    = (opc == 7'b1100011);
    assign is_ld    = (opc == 7'b0000011);
    assign is_st    = (opc == 7'b0100011);
    assign is_opi   = (opc == 7'b0010011);
    assign is_op    = (opc == 7'b0110011);
    assign legal    = is_lui | is_auipc | is_jal | is_jalr | is_br
                    | is_ld | is_st | is_opi | is_op;

    logic [11:0] dec_op;
    logic [1:0]  dec_sel;

    // Build the ALU opcode and operand-2 select from the latched instruction.
    always_comb begin
        dec_op      = '0;
        dec_op[6:0] = opc;
        if (is_op | is_opi | is_ld | is_st | is_br | is_jalr)
            dec_op[9:7] = f3;
        if (is_op)
            dec_op[11] = ir[30];
        if (is_opi && f3 == 3'b101)
            dec_op[10] = ir[30];
        unique case (1'b1)
            is_op, is_br:     dec_sel = 2'd0;
            is_lui, is_auipc: dec_sel = 2'd2;
            default:          dec_sel = 2'd1;
        endcase
    end

    logic imem_req_c, dmem_req_c, dmem_we_c;
    logic rf_we_c, rf_wsel_c, pc_we_c, pc_sel_c, ill_c;
    logic ill_q;

    // Next-state and per-state strobes.
    always_comb begin
        nxt        = state;
        imem_req_c = 1'b0;
        dmem_req_c = 1'b0;
        dmem_we_c  = 1'b0;
        rf_we_c    = 1'b0;
        rf_wsel_c  = 1'b0;
        pc_we_c    = 1'b0;
        pc_sel_c   = 1'b0;
        ill_c      = 1'b0;
        case (state)
            FETCH: begin
                imem_req_c = 1'b1;
                if (bus.imem_ack)
                    nxt = DECODE;
            end
            DECODE: begin
                if (!legal) begin
                    ill_c   = 1'b1;
                    pc_we_c = 1'b1;
                    nxt     = FETCH;
                end else begin
                    nxt = EXEC;
                end
            end
            EXEC: nxt = WAIT;
            WAIT: begin
                if (is_ld | is_st)
                    nxt = MEM;
                else if (is_br)
                    nxt = BR;
                else
                    nxt = WB;
            end
            MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = is_st;
                if (bus.dmem_ack) begin
                    if (is_st) begin
                        pc_we_c = 1'b1;
                        nxt     = FETCH;
                    end else begin
                        nxt = WB;
                    end
                end
            end
            WB: begin
                rf_we_c   = (ir[11:7] != 5'd0);
                rf_wsel_c = is_ld;
                pc_we_c   = 1'b1;
                pc_sel_c  = is_jal | is_jalr;
                nxt       = FETCH;
            end
            BR: begin
                pc_we_c  = 1'b1;
                pc_sel_c = alu_zero;
                nxt      = FETCH;
            end
            default: nxt = FETCH;
        endcase
    end

    // Reset kills every request and strobe immediately, not at the next edge.
    assign bus.imem_req = rst_n & imem_req_c;
    assign bus.dmem_req = rst_n & dmem_req_c;
    assign bus.dmem_we  = rst_n & dmem_we_c;
    assign rf_we        = rst_n & rf_we_c;
    assign rf_wsel      = rst_n & rf_wsel_c;
    assign pc_we        = rst_n & pc_we_c;
    assign pc_sel       = rst_n & pc_sel_c;
    assign illegal      = ill_q | (rst_n & ill_c);

    // State, instruction register, decoded ALU op and sticky illegal flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH;
            ir       <= '0;
            alu_op   <= '0;
            opr2_sel <= '0;
            ill_q    <= 1'b0;
        end else begin
            state <= nxt;
            if (state == FETCH && bus.imem_ack) begin
                ir    <= bus.imem_rdata;
                ill_q <= 1'b0;
            end
            if (state == DECODE) begin
                alu_op   <= legal ? dec_op : 12'd0;
                opr2_sel <= legal ? dec_sel : 2'd0;
                ill_q    <= ~legal;
            end
        end
    end

`ifdef PERF_CNT_EN
    // Free-running cycle counter and retired-instruction counter, both wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
            if (pc_we)
                instret_cnt <= instret_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: vector table plus reset/counter sequences.
// Expected per-instruction results are queued on issue and checked on retirement.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_zero = 1'b0;
    logic [31:0] ir;
    logic [11:0] alu_op;
    logic [1:0]  opr2_sel;
    logic        rf_we, rf_wsel, pc_we, pc_sel, illegal;
`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
    int          ncyc;
`endif

    multicycle_ctrl_if bus();

    multicycle_ctrl dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .ir(ir),
        .alu_op(alu_op),
        .opr2_sel(opr2_sel),
        .alu_zero(alu_zero),
        .rf_we(rf_we),
        .rf_wsel(rf_wsel),
        .pc_we(pc_we),
        .pc_sel(pc_sel),
        .illegal(illegal)
`ifdef PERF_CNT_EN
        ,
        .cycle_cnt(cycle_cnt),
        .instret_cnt(instret_cnt)
`endif
    );

    always #5 clk = ~clk;

`ifdef PERF_CNT_EN
    always @(posedge clk or negedge rst_n)
        if (!rst_n) ncyc <= 0;
        else ncyc <= ncyc + 1;
`endif

    typedef struct {
        logic [31:0] instr;
        logic        zero;
        int          dly;
        logic        noise;
        logic [11:0] op;
        logic [1:0]  sel;
        logic        psel;
        int          nrf;
        logic        wsel;
        logic        dwe;
        int          nreq;
        logic        ill;
        int          lat;
    } vec_t;

    vec_t tv[13];
    vec_t sb[$];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_instr(input vec_t v);
        int   dcnt = 0;
        int   nreq = 0;
        int   nrf = 0;
        int   lat = 0;
        logic dwe = 1'b0;
        logic wsel = 1'b0;
        logic psel = 1'b0;
        logic ill = 1'b0;
        logic done = 1'b0;
        vec_t e;
        sb.push_back(v);
        alu_zero = v.zero;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            #1;
            bus.imem_ack   = (c == 0) || v.noise;
            bus.imem_rdata = (c == 0) ? v.instr : 32'hFFFF_FFFF;
            if (bus.dmem_req) begin
                bus.dmem_ack = (dcnt == v.dly);
                dcnt++;
            end else begin
                bus.dmem_ack = v.noise;
            end
            #1;
            if (c == 0) chk("imem_req", 32'(bus.imem_req), 32'd1);
            if (bus.dmem_req) begin
                nreq++;
                dwe = dwe | bus.dmem_we;
            end
            if (rf_we) begin
                nrf++;
                wsel = rf_wsel;
            end
            if (pc_we) begin
                psel = pc_sel;
                ill  = illegal;
                lat  = c + 1;
                done = 1'b1;
            end
        end
        @(negedge clk);
        #1;
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        #1;
        e = sb.pop_front();
        if (!done) begin
            chk("timeout", 32'(done), 32'd1);
        end else begin
            chk("alu_op", 32'(alu_op), 32'(e.op));
            chk("opr2_sel", 32'(opr2_sel), 32'(e.sel));
            chk("pc_sel", 32'(psel), 32'(e.psel));
            chk("rf_we_cnt", 32'(nrf), 32'(e.nrf));
            chk("rf_wsel", 32'(wsel), 32'(e.wsel));
            chk("dmem_we", 32'(dwe), 32'(e.dwe));
            chk("dmem_req_cyc", 32'(nreq), 32'(e.nreq));
            chk("illegal", 32'(ill), 32'(e.ill));
            chk("illegal_sticky", 32'(illegal), 32'(e.ill));
            chk("latency", 32'(lat), 32'(e.lat));
            chk("ir", ir, e.instr);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_imem_req"}, 32'(bus.imem_req), 32'd0);
        chk({tag, "_dmem_req"}, 32'(bus.dmem_req), 32'd0);
        chk({tag, "_dmem_we"}, 32'(bus.dmem_we), 32'd0);
        chk({tag, "_ir"}, ir, 32'd0);
        chk({tag, "_alu_op"}, 32'(alu_op), 32'd0);
        chk({tag, "_opr2_sel"}, 32'(opr2_sel), 32'd0);
        chk({tag, "_rf_we"}, 32'(rf_we), 32'd0);
        chk({tag, "_pc_we"}, 32'(pc_we), 32'd0);
        chk({tag, "_illegal"}, 32'(illegal), 32'd0);
    endtask

    initial begin
        // instr zero dly noise op sel psel nrf wsel dwe nreq ill lat
        tv[0]  = '{32'h002081B3, 0, 0, 0, 12'b000000110011, 0, 0, 1, 0, 0, 0, 0, 5};
        tv[1]  = '{32'h4032D293, 0, 0, 0, 12'b011010010011, 1, 0, 1, 0, 0, 0, 0, 5};
        tv[2]  = '{32'h40208133, 0, 0, 1, 12'b100000110011, 0, 0, 1, 0, 0, 0, 0, 5};
        tv[3]  = '{32'h00208463, 1, 0, 0, 12'b000001100011, 0, 1, 0, 0, 0, 0, 0, 5};
        tv[4]  = '{32'h00208463, 0, 0, 0, 12'b000001100011, 0, 0, 0, 0, 0, 0, 0, 5};
        tv[5]  = '{32'h0040A303, 0, 3, 1, 12'b000100000011, 1, 0, 1, 1, 0, 4, 0, 9};
        tv[6]  = '{32'h0020A423, 0, 0, 0, 12'b000100100011, 1, 0, 0, 0, 1, 1, 0, 5};
        tv[7]  = '{32'h0000007F, 0, 0, 0, 12'b000000000000, 0, 0, 0, 0, 0, 0, 1, 2};
        tv[8]  = '{32'h010000EF, 0, 0, 0, 12'b000001101111, 1, 1, 1, 0, 0, 0, 0, 5};
        tv[9]  = '{32'h12345037, 0, 0, 0, 12'b000000110111, 2, 0, 0, 0, 0, 0, 0, 5};
        tv[10] = '{32'h00001397, 0, 0, 0, 12'b000000010111, 2, 0, 1, 0, 0, 0, 0, 5};
        tv[11] = '{32'h00008067, 0, 0, 0, 12'b000001100111, 1, 1, 0, 0, 0, 0, 0, 5};
        tv[12] = '{32'h40008093, 0, 0, 0, 12'b000000010011, 1, 0, 1, 0, 0, 0, 0, 5};

        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        bus.dmem_ack   = 1'b0;

        #3;
        chk_idle("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_imem_req", 32'(bus.imem_req), 32'd1);

        for (int i = 0; i < 13; i++)
            run_instr(tv[i]);

        // Load left hanging in MEM, then reset while the access is in flight.
        @(negedge clk);
        #1;
        alu_zero       = 1'b0;
        bus.imem_rdata = 32'h0040A303;
        bus.imem_ack   = 1'b1;
        @(negedge clk);
        #1;
        bus.imem_ack = 1'b0;
        begin
            int n = 0;
            while (!bus.dmem_req && n < 10) begin
                @(negedge clk);
                #1;
                n++;
            end
            chk("mem_reached", 32'(bus.dmem_req), 32'd1);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("mid_rst");
`ifdef PERF_CNT_EN
        chk("rst_cycle_cnt", cycle_cnt, 32'd0);
        chk("rst_instret_cnt", instret_cnt, 32'd0);
`endif
        bus.dmem_ack = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_imem_req", 32'(bus.imem_req), 32'd1);
        chk("post_rst_dmem_req", 32'(bus.dmem_req), 32'd0);
`ifdef PERF_CNT_EN
        chk("rel_cycle_cnt", cycle_cnt, 32'd0);
        chk("rel_instret_cnt", instret_cnt, 32'd0);
`endif
        @(negedge clk);
        #1;
        chk("stale_ack_dmem_req", 32'(bus.dmem_req), 32'd0);
        chk("stale_ack_pc_we", 32'(pc_we), 32'd0);
        chk("stale_ack_imem_req", 32'(bus.imem_req), 32'd1);
        bus.dmem_ack = 1'b0;

        for (int i = 0; i < 3; i++)
            run_instr(tv[0]);
`ifdef PERF_CNT_EN
        chk("instret_after_3", instret_cnt, 32'd3);
        chk("cycle_cnt", cycle_cnt, 32'(ncyc));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
